sdrc_wb_arbiter: RTL and testbench
==================================

// Module: sdrc_wb_arbiter
// PURPOSE
//  Round-robin arbiter sharing the SDRAM controller's single Wishbone application port among NUM_M masters.
//  Sits between requesters (CPU, DMA, test masters) and the sdrc wb_* slave port, all in the sys_clk domain.
//  Holds a grant for a whole Wishbone cycle (cyc high), so bursts are never interleaved.
//  A watchdog terminates any cycle the controller fails to ack, with an error to the owning master.
// PARAMETERS
//  NUM_M    4    number of masters (2..8)
//  dw       32   Wishbone data width (equals SDR_DW)
//  APP_AW   26   application address width
//  TIMEOUT  256  max sys_clk cycles from stb to ack before abort (>=4)
// PORTS
//  sys_clk     in   1              system clock; all logic on rising edge
//  sys_rst     in   1              synchronous, active-high reset
//  m_cyc_i     in   NUM_M          per-master cycle request
//  m_stb_i     in   NUM_M          per-master strobe
//  m_we_i      in   NUM_M          per-master write enable
//  m_addr_i    in   NUM_M*APP_AW   flattened addresses; master k at [k*APP_AW +: APP_AW]
//  m_dat_i     in   NUM_M*dw       flattened write data
//  m_sel_i     in   NUM_M*dw/8     flattened byte selects
//  m_ack_o     out  NUM_M          ack routed to owner only
//  m_err_o     out  NUM_M          timeout error, owner only, 1-cycle pulse
//  m_dat_o     out  dw             read data broadcast; valid only with owner's ack
//  s_cyc_o/s_stb_o/s_we_o  out 1   to sdrc
//  s_addr_o    out  APP_AW         to sdrc
//  s_dat_o     out  dw             to sdrc
//  s_sel_o     out  dw/8           to sdrc
//  s_ack_i     in   1              from sdrc
//  s_dat_i     in   dw             from sdrc
//  grant_o     out  NUM_M          one-hot owner, for debug/coverage
// BEHAVIOUR
//  Reset: state IDLE, grant_o=0, rr_ptr=0, wdog=0; all s_* and m_ack_o/m_err_o outputs 0.
//  IDLE: if any m_cyc_i, pick the first requester at or after rr_ptr, cyclically.
//    Register one-hot grant; go to OWN next cycle. Arbitration latency: 1 cycle.
//  OWN: s_* = owner's m_* (combinational mux on registered grant).
//    m_ack_o[owner]=s_ack_i; m_dat_o=s_dat_i.
//  OWN exit: owner drops m_cyc_i -> IDLE next cycle; rr_ptr=owner+1 mod NUM_M.
//    Next grant earliest 1 cycle after release (1 idle bubble).
//  Watchdog: wdog counts cycles while s_stb_o=1 and s_ack_i=0; clears on ack or stb low.
//    At wdog==TIMEOUT-1 without ack: m_err_o[owner]=1 for 1 cycle; enter ABORT.
//  ABORT: s_cyc_o=s_stb_o=0; acks suppressed. Hold until owner drops m_cyc_i, then IDLE, rr_ptr advanced.
//  s_ack_i arriving in IDLE or ABORT: ignored, never forwarded.
//  s_ack_i in the same cycle the owner drops cyc: forwarded; release still occurs.
//  Non-owners: m_ack_o/m_err_o held 0. Requests stay pending, never dropped.
//  Masters are not required to hold stb across the whole cycle.
//  Mid-operation sys_rst: outputs return to reset values next edge; in-flight transfer abandoned, no ack/err.
//  Fairness: any requester is granted within NUM_M-1 ownership periods.
// STRUCTURE
//  sdrc_pkg: arb_state_e {IDLE, OWN, ABORT}; default TIMEOUT constant.
//  Sub-module sdrc_rr_pick: combinational one-hot round-robin select (req, ptr -> gnt).
//  Top holds the FSM, grant/ptr registers, watchdog and muxes.
// TESTING
//  Single master 0, write addr 0x100, data 0xDEADBEEF:
//    grant_o=0001 one cycle after cyc; s_* mirrors m0; ack reaches m0 only.
//  Masters 0..3 request together from reset:
//    grants in order 0,1,2,3, each after prior release + 1 bubble.
//  Master 2 burst of 4 reads while m1 requests:
//    m1 not granted until m2 cyc drops; all 4 acks go to m2.
//  Slave never acks, TIMEOUT=16:
//    m_err_o pulse 16 cycles after stb; s_cyc_o low next; after owner release, next requester granted.
//  Assert sys_rst during an owned write:
//    next edge grant_o=0, s_cyc_o=0, no ack/err; with m3 requesting, m3 granted 1 cycle after reset deasserts.
//  Stray s_ack_i in IDLE: no m_ack_o asserted.

Source files
------------

// File: rtl/sdrc_wb_arbiter_pkg.sv
// Shared types and defaults for the SDRAM controller Wishbone port arbiter.
package sdrc_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn   = 2'd1,
    StAbort = 2'd2
  } arb_state_e;

  localparam int unsigned DefNumM    = 4;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned DefAppAw   = 26;
  localparam int unsigned DefTimeout = 256;

  // Index following idx on an n-entry ring.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/sdrc_wb_arbiter_if.sv
// Bundle of requester-side and sdrc-side Wishbone signals around the arbiter.
// master: the environment (requesters plus the sdrc slave port).
// slave:  the arbiter itself.
interface sdrc_wb_arbiter_if import sdrc_wb_arbiter_pkg::*; #(
  parameter int unsigned NUM_M  = DefNumM,
  parameter int unsigned dw     = DefDw,
  parameter int unsigned APP_AW = DefAppAw
);

  logic [NUM_M-1:0]          m_cyc_i;
  logic [NUM_M-1:0]          m_stb_i;
  logic [NUM_M-1:0]          m_we_i;
  logic [NUM_M*APP_AW-1:0]   m_addr_i;
  logic [NUM_M*dw-1:0]       m_dat_i;
  logic [NUM_M*dw/8-1:0]     m_sel_i;
  logic [NUM_M-1:0]          m_ack_o;
  logic [NUM_M-1:0]          m_err_o;
  logic [dw-1:0]             m_dat_o;

  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [APP_AW-1:0]         s_addr_o;
  logic [dw-1:0]             s_dat_o;
  logic [dw/8-1:0]           s_sel_o;
  logic                      s_ack_i;
  logic [dw-1:0]             s_dat_i;

  logic [NUM_M-1:0]          grant_o;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o,
           grant_o
  );

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o,
           grant_o
  );

endinterface

// File: rtl/sdrc_wb_arbiter_rr_pick.sv
// Combinational round-robin select: first requester at or after ptr, cyclically.
module sdrc_wb_arbiter_rr_pick import sdrc_wb_arbiter_pkg::*; #(
  parameter int unsigned NUM_M = DefNumM
) (
  input  logic [NUM_M-1:0]         req_i,
  input  logic [$clog2(NUM_M)-1:0] ptr_i,
  output logic [NUM_M-1:0]         gnt_o
);

  localparam int unsigned PtrW = $clog2(NUM_M);

  logic [PtrW-1:0] idx;
  logic            found;

  // Walk the ring starting at ptr and keep the first requester found.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NUM_M);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin arbiter sharing the sdrc Wishbone application port among NUM_M masters.
// A grant is held for a whole Wishbone cycle; a watchdog aborts cycles the sdrc never acks.
module sdrc_wb_arbiter import sdrc_wb_arbiter_pkg::*; #(
  parameter int unsigned NUM_M   = DefNumM,
  parameter int unsigned dw      = DefDw,
  parameter int unsigned APP_AW  = DefAppAw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  sdrc_wb_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(NUM_M);
  localparam int unsigned SelW = dw / 8;
  localparam int unsigned WdW  = $clog2(TIMEOUT);

  arb_state_e        state_q;
  logic [NUM_M-1:0]  grant_q;
  logic [NUM_M-1:0]  err_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [WdW-1:0]    wdog_q;

  logic [NUM_M-1:0]  pick_gnt;
  logic [PtrW-1:0]   next_ptr;
  logic [APP_AW-1:0] mux_addr;
  logic [dw-1:0]     mux_dat;
  logic [SelW-1:0]   mux_sel;
  logic              owned;
  logic              owner_cyc;
  logic              owner_stb;
  logic              owner_we;
  logic              s_stb;
  logic              wd_fire;

  sdrc_wb_arbiter_rr_pick #(
    .NUM_M (NUM_M)
  ) u_rr_pick (
    .req_i (bus.m_cyc_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt)
  );

  // Select the owner's bus fields and the pointer slot just past the owner.
  always_comb begin
    mux_addr = '0;
    mux_dat  = '0;
    mux_sel  = '0;
    next_ptr = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (grant_q[k]) begin
        mux_addr = bus.m_addr_i[k*APP_AW +: APP_AW];
        mux_dat  = bus.m_dat_i[k*dw +: dw];
        mux_sel  = bus.m_sel_i[k*SelW +: SelW];
        next_ptr = PtrW'(rr_next(k, NUM_M));
      end
    end
  end

  assign owned     = (state_q == StOwn);
  assign owner_cyc = |(grant_q & bus.m_cyc_i);
  assign owner_stb = |(grant_q & bus.m_cyc_i & bus.m_stb_i);
  assign owner_we  = |(grant_q & bus.m_we_i);
  assign s_stb     = owned & owner_stb;
  assign wd_fire   = s_stb && !bus.s_ack_i && (wdog_q == WdW'(TIMEOUT - 1));

  assign bus.s_cyc_o  = owned & owner_cyc;
  assign bus.s_stb_o  = s_stb;
  assign bus.s_we_o   = owned & owner_we;
  assign bus.s_addr_o = owned ? mux_addr : '0;
  assign bus.s_dat_o  = owned ? mux_dat : '0;
  assign bus.s_sel_o  = owned ? mux_sel : '0;
  // Acks only reach the owner, and only while the cycle is live on the sdrc side.
  assign bus.m_ack_o  = (owned && bus.s_ack_i) ? grant_q : '0;
  assign bus.m_err_o  = err_q;
  assign bus.m_dat_o  = bus.s_dat_i;
  assign bus.grant_o  = grant_q;

  // Arbitration FSM with grant/pointer registers, watchdog and error pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      err_q    <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      err_q <= '0;
      unique case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (|bus.m_cyc_i) begin
            grant_q <= pick_gnt;
            state_q <= StOwn;
          end
        end
        StOwn: begin
          if (!owner_cyc) begin
            // Release takes priority over a watchdog expiry in the same cycle.
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            wdog_q   <= '0;
          end else if (wd_fire) begin
            err_q   <= grant_q;
            state_q <= StAbort;
            wdog_q  <= '0;
          end else if (s_stb && !bus.s_ack_i) begin
            wdog_q <= wdog_q + WdW'(1);
          end else begin
            wdog_q <= '0;
          end
        end
        StAbort: begin
          wdog_q <= '0;
          if (!owner_cyc) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          wdog_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Self-checking bench for sdrc_wb_arbiter: directed scenarios plus randomized
// round-robin traffic compared against an index-arithmetic arbitration model.
module tb_sdrc_wb_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned TO = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;
  int wait_cnt[NM];

  sdrc_wb_arbiter_if #(.NUM_M(NM), .dw(DW), .APP_AW(AW)) bus ();

  sdrc_wb_arbiter #(
    .NUM_M   (NM),
    .dw      (DW),
    .APP_AW  (AW),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected to finish");
    $fatal(1);
  end

  // First requester at or after ptr on the ring, -1 if none.
  function automatic int pick_model(logic [NM-1:0] req, int ptr);
    for (int i = 0; i < NM; i++) begin
      int idx;
      idx = (ptr + i) % NM;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_master(int k, bit cyc, bit stb, bit we, logic [AW-1:0] a,
                              logic [DW-1:0] d, logic [3:0] sel);
    bus.m_cyc_i[k] = cyc;
    bus.m_stb_i[k] = stb;
    bus.m_we_i[k]  = we;
    bus.m_addr_i[k*AW +: AW] = a;
    bus.m_dat_i[k*DW +: DW]  = d;
    bus.m_sel_i[k*4 +: 4]    = sel;
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i  = '0;
    bus.m_stb_i  = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_dat_i  = '0;
    bus.m_sel_i  = '0;
    bus.s_ack_i  = 1'b0;
    bus.s_dat_i  = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    sys_rst = 1'b0;
    model_ptr = 0;
  endtask

  // Raise cyc for every master in add with random stb/we/fields.
  task automatic request(logic [NM-1:0] add);
    for (int k = 0; k < NM; k++) begin
      if (add[k]) begin
        drive_master(k, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom), $urandom, 4'($urandom));
        wait_cnt[k] = 0;
      end
    end
  endtask

  // One transfer by owner k with a number of wait states before the ack.
  task automatic beat(int k, bit we, int waits);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    logic [3:0]    sel;
    a   = AW'($urandom);
    d   = $urandom;
    rd  = $urandom;
    sel = 4'($urandom_range(1, 15));
    drive_master(k, 1'b1, 1'b1, we, a, d, sel);
    bus.s_ack_i = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = rd;
      end
      #1;
      n_checks++;
      if (bus.s_stb_o !== 1'b1 || bus.s_cyc_o !== 1'b1 || bus.s_addr_o !== a ||
          bus.s_we_o !== we || bus.s_sel_o !== sel || bus.s_dat_o !== d) begin
        n_fail++;
        $display("FAIL beat_mux m%0d: got cyc=%b stb=%b addr=%h we=%b sel=%h dat=%h, want 1 1 %h %b %h %h",
                 k, bus.s_cyc_o, bus.s_stb_o, bus.s_addr_o, bus.s_we_o, bus.s_sel_o,
                 bus.s_dat_o, a, we, sel, d);
      end
      n_checks++;
      if (bus.m_ack_o !== ((w == waits) ? 4'(1 << k) : 4'b0)) begin
        n_fail++;
        $display("FAIL beat_ack m%0d w%0d: got %b want %b", k, w, bus.m_ack_o,
                 (w == waits) ? 4'(1 << k) : 4'b0);
      end
      if (w == waits && !we) begin
        n_checks++;
        if (bus.m_dat_o !== rd) begin
          n_fail++;
          $display("FAIL beat_rdata m%0d: got %h want %h", k, bus.m_dat_o, rd);
        end
      end
      tick();
    end
    bus.s_ack_i    = 1'b0;
    bus.m_stb_i[k] = 1'b0;
  endtask

  // Fairness: nobody waits through more than NM-1 other ownership periods.
  task automatic note_grant(int g);
    n_checks++;
    if (wait_cnt[g] > NM - 1) begin
      n_fail++;
      $display("FAIL fairness m%0d: waited %0d periods, want <= %0d", g, wait_cnt[g], NM - 1);
    end
    wait_cnt[g] = 0;
    for (int k = 0; k < NM; k++) begin
      if (k != g && bus.m_cyc_i[k]) wait_cnt[k]++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    sys_rst = 1'b1;
    drive_master(2, 1'b1, 1'b1, 1'b1, 26'h3ff, 32'h1234_5678, 4'hf);
    bus.s_ack_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0) begin
      n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant_o);
    end
    n_checks++;
    if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s_ctrl: got cyc=%b stb=%b we=%b want 0 0 0",
               bus.s_cyc_o, bus.s_stb_o, bus.s_we_o);
    end
    n_checks++;
    if (bus.s_addr_o !== '0 || bus.s_dat_o !== '0 || bus.s_sel_o !== '0) begin
      n_fail++;
      $display("FAIL reset_s_data: got addr=%h dat=%h sel=%h want 0 0 0",
               bus.s_addr_o, bus.s_dat_o, bus.s_sel_o);
    end
    n_checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_m_resp: got ack=%b err=%b want 0000 0000", bus.m_ack_o, bus.m_err_o);
    end
    clear_inputs();
    sys_rst = 1'b0;
    model_ptr = 0;
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", bus.grant_o);
    end
  endtask

  task automatic test_single_write();
    drive_master(0, 1'b1, 1'b1, 1'b1, 26'h100, 32'hDEADBEEF, 4'hf);
    #1;
    n_checks++;
    if (bus.grant_o !== 4'b0 || bus.s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_latency: got grant=%b s_cyc=%b want 0000 0", bus.grant_o, bus.s_cyc_o);
    end
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0001) begin
      n_fail++; $display("FAIL sw_grant: got %b want 0001", bus.grant_o);
    end
    n_checks++;
    if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1 ||
        bus.s_addr_o !== 26'h100 || bus.s_dat_o !== 32'hDEADBEEF || bus.s_sel_o !== 4'hf) begin
      n_fail++;
      $display("FAIL sw_mirror: got %b%b%b addr=%h dat=%h sel=%h want 111 100 deadbeef f",
               bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_dat_o, bus.s_sel_o);
    end
    n_checks++;
    if (bus.m_ack_o !== 4'b0) begin
      n_fail++; $display("FAIL sw_no_early_ack: got %b want 0000", bus.m_ack_o);
    end
    // Ack lands in the same cycle the owner drops cyc.
    bus.s_ack_i    = 1'b1;
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0001) begin
      n_fail++; $display("FAIL sw_ack_on_release: got %b want 0001", bus.m_ack_o);
    end
    tick();
    bus.s_ack_i = 1'b0;
    model_ptr = 1;
    n_checks++;
    if (bus.grant_o !== 4'b0) begin
      n_fail++; $display("FAIL sw_release: got %b want 0000", bus.grant_o);
    end
  endtask

  task automatic test_stray_ack();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.grant_o !== 4'b0) begin
        n_fail++;
        $display("FAIL stray_ack c%0d: got ack=%b err=%b grant=%b want 0000 0000 0000",
                 i, bus.m_ack_o, bus.m_err_o, bus.grant_o);
      end
      tick();
    end
    bus.s_ack_i = 1'b0;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int k = 0; k < NM; k++) drive_master(k, 1'b1, 1'b0, 1'b0, AW'(k), '0, 4'hf);
    for (int i = 0; i < NM; i++) begin
      tick();
      n_checks++;
      if (bus.grant_o !== 4'(1 << i)) begin
        n_fail++; $display("FAIL all4_grant #%0d: got %b want %b", i, bus.grant_o, 4'(1 << i));
      end
      beat(i, 1'(i), 1);
      bus.m_cyc_i[i] = 1'b0;
      tick();
      n_checks++;
      if (bus.grant_o !== 4'b0) begin
        n_fail++; $display("FAIL all4_bubble #%0d: got %b want 0000", i, bus.grant_o);
      end
    end
    model_ptr = 0;
  endtask

  task automatic test_burst();
    int g;
    drive_master(2, 1'b1, 1'b0, 1'b0, '0, '0, 4'hf);
    g = pick_model(bus.m_cyc_i, model_ptr);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'(1 << g) || g != 2) begin
      n_fail++; $display("FAIL burst_grant: got %b want 0100", bus.grant_o);
    end
    drive_master(1, 1'b1, 1'b1, 1'b0, AW'($urandom), $urandom, 4'hf);
    for (int b = 0; b < 4; b++) begin
      beat(2, 1'b0, $urandom_range(0, 2));
      n_checks++;
      if (bus.grant_o !== 4'b0100) begin
        n_fail++; $display("FAIL burst_hold b%0d: got %b want 0100", b, bus.grant_o);
      end
    end
    bus.m_cyc_i[2] = 1'b0;
    model_ptr = 3;
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0) begin
      n_fail++; $display("FAIL burst_bubble: got %b want 0000", bus.grant_o);
    end
    g = pick_model(bus.m_cyc_i, model_ptr);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'(1 << g)) begin
      n_fail++; $display("FAIL burst_next: got %b want %b", bus.grant_o, 4'(1 << g));
    end
    bus.m_cyc_i[g] = 1'b0;
    bus.m_stb_i[g] = 1'b0;
    model_ptr = (g + 1) % NM;
    tick();
  endtask

  task automatic test_round_robin(int rounds);
    int g;
    int nb;
    logic [NM-1:0] add;
    for (int k = 0; k < NM; k++) wait_cnt[k] = 0;
    for (int r = 0; r < rounds; r++) begin
      if (bus.m_cyc_i == '0) request(NM'($urandom_range(1, 15)));
      g = pick_model(bus.m_cyc_i, model_ptr);
      tick();
      n_checks++;
      if (bus.grant_o !== 4'(1 << g)) begin
        n_fail++; $display("FAIL rr_grant r%0d: got %b want %b", r, bus.grant_o, 4'(1 << g));
      end
      note_grant(g);
      add = NM'($urandom) & ~bus.m_cyc_i;
      request(add);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        beat(g, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        n_checks++;
        if (bus.grant_o !== 4'(1 << g)) begin
          n_fail++; $display("FAIL rr_hold r%0d: got %b want %b", r, bus.grant_o, 4'(1 << g));
        end
      end
      bus.m_cyc_i[g] = 1'b0;
      model_ptr = (g + 1) % NM;
      tick();
      n_checks++;
      if (bus.grant_o !== 4'b0) begin
        n_fail++; $display("FAIL rr_bubble r%0d: got %b want 0000", r, bus.grant_o);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int k;
    int j;
    int g;
    k = $urandom_range(0, NM - 1);
    j = (k + 1 + $urandom_range(0, NM - 2)) % NM;
    drive_master(k, 1'b1, 1'b0, 1'b0, '0, '0, 4'hf);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'(1 << k)) begin
      n_fail++; $display("FAIL to_grant: got %b want %b", bus.grant_o, 4'(1 << k));
    end
    drive_master(j, 1'b1, 1'b1, 1'b0, AW'($urandom), $urandom, 4'hf);
    drive_master(k, 1'b1, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'hf);
    for (int c = 0; c < int'(TO); c++) begin
      #1;
      n_checks++;
      if (bus.m_err_o !== 4'b0 || bus.s_cyc_o !== 1'b1) begin
        n_fail++;
        $display("FAIL to_early c%0d: got err=%b s_cyc=%b want 0000 1", c, bus.m_err_o,
                 bus.s_cyc_o);
      end
      tick();
    end
    n_checks++;
    if (bus.m_err_o !== 4'(1 << k)) begin
      n_fail++; $display("FAIL to_err: got %b want %b", bus.m_err_o, 4'(1 << k));
    end
    n_checks++;
    if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.grant_o !== 4'(1 << k)) begin
      n_fail++;
      $display("FAIL to_abort: got s_cyc=%b s_stb=%b grant=%b want 0 0 %b",
               bus.s_cyc_o, bus.s_stb_o, bus.grant_o, 4'(1 << k));
    end
    tick();
    n_checks++;
    if (bus.m_err_o !== 4'b0) begin
      n_fail++; $display("FAIL to_err_pulse: got %b want 0000", bus.m_err_o);
    end
    bus.s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0 || bus.grant_o !== 4'(1 << k)) begin
      n_fail++;
      $display("FAIL to_abort_hold: got ack=%b grant=%b want 0000 %b", bus.m_ack_o,
               bus.grant_o, 4'(1 << k));
    end
    bus.s_ack_i    = 1'b0;
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
    model_ptr = (k + 1) % NM;
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0) begin
      n_fail++; $display("FAIL to_release: got %b want 0000", bus.grant_o);
    end
    g = pick_model(bus.m_cyc_i, model_ptr);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'(1 << g) || g != j) begin
      n_fail++; $display("FAIL to_next: got %b want %b", bus.grant_o, 4'(1 << j));
    end
    bus.m_cyc_i[j] = 1'b0;
    bus.m_stb_i[j] = 1'b0;
    model_ptr = (j + 1) % NM;
    tick();
  endtask

  task automatic test_reset_mid();
    int g;
    drive_master(1, 1'b1, 1'b0, 1'b0, '0, '0, 4'hf);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'b0010) begin
      n_fail++; $display("FAIL rstmid_grant: got %b want 0010", bus.grant_o);
    end
    drive_master(3, 1'b1, 1'b0, 1'b0, '0, '0, 4'hf);
    drive_master(1, 1'b1, 1'b1, 1'b1, AW'($urandom), $urandom, 4'hf);
    sys_rst = 1'b1;
    tick();
    bus.m_cyc_i[1] = 1'b0;
    bus.m_stb_i[1] = 1'b0;
    bus.s_ack_i    = 1'b1;
    #1;
    n_checks++;
    if (bus.grant_o !== 4'b0 || bus.s_cyc_o !== 1'b0 || bus.m_ack_o !== 4'b0 ||
        bus.m_err_o !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got grant=%b s_cyc=%b ack=%b err=%b want 0000 0 0000 0000",
               bus.grant_o, bus.s_cyc_o, bus.m_ack_o, bus.m_err_o);
    end
    bus.s_ack_i = 1'b0;
    sys_rst = 1'b0;
    model_ptr = 0;
    g = pick_model(bus.m_cyc_i, model_ptr);
    tick();
    n_checks++;
    if (bus.grant_o !== 4'(1 << g) || g != 3) begin
      n_fail++; $display("FAIL rstmid_regrant: got %b want 1000", bus.grant_o);
    end
    bus.m_cyc_i[3] = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_stray_ack();
    test_all_four();
    test_burst();
    test_round_robin(40);
    for (int i = 0; i < 3; i++) test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
